// File: rtl/inst_rom_ctrl_pkg.sv
// Shared types and bus constants for the instruction-fetch buffer controller.
package inst_rom_ctrl_pkg;
  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;
  localparam logic [INST_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    IRC_IDLE  = 2'd0,
    IRC_FETCH = 2'd1,
    IRC_FILL  = 2'd2
  } irc_state_e;
endpackage

// File: rtl/inst_rom_ctrl_fetch_buf.sv
// Direct-mapped fetch buffer storage: one write port, one async read port,
// global clear of the valid bits that overrides a same-edge write.
module inst_rom_ctrl_fetch_buf
  import inst_rom_ctrl_pkg::*;
#(
  parameter int LINES  = 4,
  parameter int IDX_W  = 2,
  parameter int TAG_W  = 28,
  parameter int DATA_W = INST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [TAG_W-1:0]  wtag,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic              rvalid,
  output logic [TAG_W-1:0]  rtag,
  output logic [DATA_W-1:0] rdata
);
  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (clr) begin
      valid <= '0;
    end else if (we) begin
      valid[widx] <= 1'b1;
    end
  end

  // Storage is not reset; a line is only ever observed through its valid bit.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[widx]  <= wtag;
      data_mem[widx] <= wdata;
    end
  end

  assign rvalid = valid[ridx];
  assign rtag   = tag_mem[ridx];
  assign rdata  = data_mem[ridx];
endmodule

// File: rtl/inst_rom_ctrl.sv
// Instruction-fetch responder: serves 32-bit fetches from a byte-wide flash
// through a small direct-mapped buffer, stalling the CPU during line fills.
module inst_rom_ctrl
  import inst_rom_ctrl_pkg::*;
#(
  parameter int LINES    = 4,
  parameter int FLASH_AW = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rom_ce_i,
  input  logic [INST_ADDR_W-1:0] rom_addr_i,
  output logic [INST_W-1:0]      rom_data_o,
  output logic                   stallreq_o,
  input  logic                   inval_i,
  output logic                   flash_req_o,
  output logic [FLASH_AW-1:0]    flash_addr_o,
  input  logic                   flash_ack_i,
  input  logic [7:0]             flash_data_i
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = INST_ADDR_W - IDX_W - 2;

  irc_state_e             state;
  logic [1:0]             beat;
  logic [INST_ADDR_W-1:2] cap_addr;
  logic [INST_W-1:0]      asm_word;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              buf_valid;
  logic [TAG_W-1:0]  buf_tag;
  logic [INST_W-1:0] buf_data;
  logic              hit;
  logic              miss_idle;
  logic              unused_addr_lsb;

  assign idx             = rom_addr_i[IDX_W+1:2];
  assign tag             = rom_addr_i[INST_ADDR_W-1:IDX_W+2];
  assign unused_addr_lsb = ^rom_addr_i[1:0];
  assign hit             = rom_ce_i & buf_valid & (buf_tag == tag);
  assign miss_idle       = rom_ce_i & ~hit & (state == IRC_IDLE);

  inst_rom_ctrl_fetch_buf #(
    .LINES  (LINES),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .DATA_W (INST_W)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .clr    (inval_i),
    .we     (state == IRC_FILL),
    .widx   (cap_addr[IDX_W+1:2]),
    .wtag   (cap_addr[INST_ADDR_W-1:IDX_W+2]),
    .wdata  (asm_word),
    .ridx   (idx),
    .rvalid (buf_valid),
    .rtag   (buf_tag),
    .rdata  (buf_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IRC_IDLE;
      beat  <= 2'd0;
    end else begin
      unique case (state)
        IRC_IDLE: begin
          if (miss_idle) begin
            state <= IRC_FETCH;
            beat  <= 2'd0;
          end
        end
        IRC_FETCH: begin
          if (flash_ack_i) begin
            beat <= beat + 2'd1;
            if (beat == 2'd3) state <= IRC_FILL;
          end
        end
        IRC_FILL: state <= IRC_IDLE;
        default:  state <= IRC_IDLE;
      endcase
    end
  end

  // Miss address and the big-endian byte assembler: first beat ends up in [31:24].
  always_ff @(posedge clk) begin
    if (miss_idle) cap_addr <= rom_addr_i[INST_ADDR_W-1:2];
    if (state == IRC_FETCH && flash_ack_i) asm_word <= {asm_word[INST_W-9:0], flash_data_i};
  end

  assign flash_req_o  = (state == IRC_FETCH);
  assign flash_addr_o = {cap_addr[FLASH_AW-1:2], beat};
  assign stallreq_o   = rst & rom_ce_i & ((state != IRC_IDLE) | ~hit);
  assign rom_data_o   = (rst && state == IRC_IDLE && hit) ? buf_data : ZERO_WORD;
endmodule

// File: tb/tb_inst_rom_ctrl.sv
// Bench for inst_rom_ctrl: directed scenarios plus random traffic, every cycle
// checked against a transaction-level buffer model and an ideal flash image.
module tb_inst_rom_ctrl;
  localparam int LINES    = 4;
  localparam int FLASH_AW = 20;
  localparam int IDX_W    = $clog2(LINES);

  logic                clk = 1'b0;
  logic                rst;
  logic                rom_ce;
  logic [31:0]         rom_addr;
  logic [31:0]         rom_data;
  logic                stall;
  logic                inval;
  logic                flash_req;
  logic [FLASH_AW-1:0] flash_addr;
  logic                flash_ack;
  logic [7:0]          flash_data;

  always #5 clk = ~clk;

  inst_rom_ctrl #(.LINES(LINES), .FLASH_AW(FLASH_AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .rom_ce_i     (rom_ce),
    .rom_addr_i   (rom_addr),
    .rom_data_o   (rom_data),
    .stallreq_o   (stall),
    .inval_i      (inval),
    .flash_req_o  (flash_req),
    .flash_addr_o (flash_addr),
    .flash_ack_i  (flash_ack),
    .flash_data_i (flash_data)
  );

  // Flash image: byte k holds k; ack after fl_delay waiting cycles per beat.
  int fl_delay = 0;
  int fl_wait  = 0;
  assign flash_ack  = flash_req && (fl_wait >= fl_delay);
  assign flash_data = flash_addr[7:0];
  always @(posedge clk) begin
    if (!flash_req || flash_ack) fl_wait <= 0;
    else                         fl_wait <= fl_wait + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model: which addresses each line holds, plus the outstanding miss.
  bit          mvalid [LINES];
  logic [31:0] mline  [LINES];
  bit          busy = 1'b0;
  int          got  = 0;
  logic [31:0] pend = '0;
  logic        obs_stall;

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 2) % LINES);
  endfunction

  function automatic bit same_tag(input logic [31:0] a, input logic [31:0] b);
    return (a >> (2 + IDX_W)) == (b >> (2 + IDX_W));
  endfunction

  function automatic logic [31:0] golden(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0] & 8'hFC;
    return {b, b + 8'd1, b + 8'd2, b + 8'd3};
  endfunction

  task automatic step();
    bit          hit;
    logic [31:0] e_data;
    logic        e_stall;
    logic        e_req;
    logic [1:0]  g;
    int          ln;
    @(negedge clk);
    hit = 0; e_data = '0; e_stall = 0; e_req = 0;
    ln  = line_of(rom_addr);
    if (!rst) begin
      busy = 0;
      got  = 0;
      for (int i = 0; i < LINES; i++) mvalid[i] = 0;
    end else if (!busy) begin
      hit     = rom_ce && mvalid[ln] && same_tag(mline[ln], rom_addr);
      e_data  = hit ? golden(rom_addr) : 32'h0;
      e_stall = rom_ce && !hit;
    end else begin
      e_stall = rom_ce;
      e_req   = (got < 4);
    end
    chk("data", rom_data, e_data);
    chk("stall", 32'(stall), 32'(e_stall));
    chk("req", 32'(flash_req), 32'(e_req));
    if (e_req) begin
      g = got[1:0];
      chk("faddr", 32'(flash_addr), 32'({pend[FLASH_AW-1:2], g}));
    end
    obs_stall = stall;
    if (rst) begin
      if (!busy) begin
        if (e_stall) begin
          busy = 1; pend = rom_addr; got = 0;
        end
      end else if (got < 4) begin
        if (flash_ack) got++;
      end else begin
        mvalid[line_of(pend)] = 1;
        mline[line_of(pend)]  = pend;
        busy = 0;
      end
      if (inval) for (int i = 0; i < LINES; i++) mvalid[i] = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, output int n);
    rom_ce   = 1'b1;
    rom_addr = a;
    n = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (!obs_stall) break;
      n++;
    end
  endtask

  task automatic fetch_lat(input string tag, input logic [31:0] a, input int exp);
    int n;
    fetch(a, n);
    chk(tag, 32'(n), 32'(exp));
  endtask

  task automatic inval_pulse();
    rom_ce = 1'b0;
    inval  = 1'b1;
    step();
    inval  = 1'b0;
  endtask

  logic [31:0] tag_pool [4] = '{32'h0000_0000, 32'h0000_0010, 32'h0010_0000, 32'h8000_0000};

  initial begin
    int n;
    rst = 1'b0; rom_ce = 1'b0; rom_addr = '0; inval = 1'b0;
    for (int i = 0; i < LINES; i++) mvalid[i] = 0;
    step();
    rom_ce = 1'b1;
    step();
    rst = 1'b1;
    rom_ce = 1'b0;
    step();

    fetch_lat("t1_lat", 32'h0, 6);
    chk("t1_data", rom_data, 32'h0001_0203);

    fetch_lat("t2_hit0", 32'h0, 0);
    fetch_lat("t2_miss4", 32'h4, 6);
    chk("t2_data4", rom_data, 32'h0405_0607);
    fetch_lat("t2_miss10", 32'h10, 6);
    fetch_lat("t2_evict0", 32'h0, 6);

    fl_delay = 3;
    fetch_lat("t3_lat", 32'h20, 18);
    chk("t3_data", rom_data, 32'h2021_2223);
    fl_delay = 0;

    inval_pulse();
    rom_ce = 1'b1; rom_addr = 32'h0; n = 0;
    for (int i = 0; i < 80; i++) begin
      if (n == 3) rom_addr = 32'h8;
      step();
      if (!obs_stall) break;
      n++;
    end
    chk("t4_lat", 32'(n), 32'd12);
    chk("t4_data8", rom_data, 32'h0809_0A0B);
    fetch_lat("t4_hit0", 32'h0, 0);

    inval_pulse();
    rom_ce = 1'b1; rom_addr = 32'h0;
    repeat (5) step();
    inval = 1'b1;
    step();
    inval = 1'b0;
    fetch_lat("t5_refetch", 32'h0, 6);
    fetch_lat("t5_fill4", 32'h4, 6);
    fetch_lat("t5_fill8", 32'h8, 6);
    fetch_lat("t5_fillc", 32'hC, 6);
    fetch_lat("t5_hitc", 32'hC, 0);
    inval_pulse();
    for (int i = 0; i < 4; i++) fetch_lat("t5_allmiss", 32'(i * 4), 6);

    rom_ce = 1'b1; rom_addr = 32'h30;
    step(); step();
    rom_ce = 1'b0;
    repeat (6) step();
    fetch_lat("x_ce0_hit", 32'h30, 0);

    rom_ce = 1'b1; rom_addr = 32'h44;
    step(); step();
    #3;
    rst = 1'b0;
    #1;
    chk("t6_req", 32'(flash_req), 32'd0);
    chk("t6_stall", 32'(stall), 32'd0);
    chk("t6_data", rom_data, 32'h0);
    step();
    rst = 1'b1;
    fetch_lat("t6_after", 32'h0, 6);

    for (int i = 0; i < 400; i++) begin
      rom_ce   = ($urandom % 4) != 0;
      rom_addr = tag_pool[$urandom % 4] | 32'(($urandom % LINES) << 2) | 32'($urandom % 4);
      inval    = ($urandom % 25) == 0;
      fl_delay = int'($urandom % 3);
      step();
    end
    inval = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
